// File: rtl/muldiv_unit.sv
// Iterative RV32 M-extension execute unit: 32-cycle shift-add MUL and restoring signed DIV.
// Holds the pipeline through stall while an operation runs; result is registered and held.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            busy,
  output logic            stall
);

  typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

  localparam logic [3:0] CTRL_MUL = 4'b0011;
  localparam logic [3:0] CTRL_DIV = 4'b0100;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t state, state_next;

  logic            is_mul, is_div, accept, div_zero, div_ovf, last_iter;
  logic [4:0]      cnt;
  logic [XLEN-1:0] a_reg, b_reg, rem, mul_sum;
  logic [XLEN:0]   rem_shift;
  logic [XLEN-1:0] sub, rem_next, quo_next, div_res;
  logic            ge, neg;

  assign is_mul    = (alu_ctrl == CTRL_MUL);
  assign is_div    = (alu_ctrl == CTRL_DIV);
  assign accept    = (state == IDLE) && start && !flush && (is_mul || is_div);
  assign div_zero  = (op_b == '0);
  assign div_ovf   = (op_a == INT_MIN) && (op_b == '1);
  assign last_iter = (cnt == 5'd31);

  // MUL: rem is the accumulator, a_reg the left-shifting multiplicand, b_reg the right-shifting multiplier.
  assign mul_sum = rem + (b_reg[0] ? a_reg : '0);

  // DIV: a_reg shifts dividend bits out of the top and quotient bits in at the bottom.
  assign rem_shift = {rem, a_reg[XLEN-1]};
  assign ge        = (rem_shift >= {1'b0, b_reg});
  assign sub       = rem_shift[XLEN-1:0] - b_reg;
  assign rem_next  = ge ? sub : rem_shift[XLEN-1:0];
  assign quo_next  = {a_reg[XLEN-2:0], ge};
  assign div_res   = neg ? -quo_next : quo_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mul)                  state_next = MUL_RUN;
          else if (div_zero || div_ovf) state_next = DONE;
          else                          state_next = DIV_RUN;
        end
      end
      MUL_RUN, DIV_RUN: begin
        if (flush)          state_next = IDLE;
        else if (last_iter) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign stall = !rst && (accept || state == MUL_RUN || state == DIV_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      rem    <= '0;
      neg    <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            rem <= '0;
            if (is_mul) begin
              a_reg <= op_a;
              b_reg <= op_b;
            end else begin
              a_reg <= op_a[XLEN-1] ? -op_a : op_a;
              b_reg <= op_b[XLEN-1] ? -op_b : op_b;
              neg   <= op_a[XLEN-1] ^ op_b[XLEN-1];
              if (div_zero)     result <= '1;
              else if (div_ovf) result <= INT_MIN;
            end
          end
        end
        MUL_RUN: begin
          if (!flush) begin
            rem   <= mul_sum;
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
            cnt   <= cnt + 5'd1;
            if (last_iter) result <= mul_sum;
          end
        end
        DIV_RUN: begin
          if (!flush) begin
            rem   <= rem_next;
            a_reg <= quo_next;
            cnt   <= cnt + 5'd1;
            if (last_iter) result <= div_res;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed cases plus random MUL/DIV, checked against an arithmetic model.
module tb_muldiv_unit;

  localparam logic [3:0] CTRL_MUL = 4'b0011;
  localparam logic [3:0] CTRL_DIV = 4'b0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a, op_b;
  logic        flush;
  logic [31:0] result;
  logic        done, busy, stall;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_ctrl(alu_ctrl),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .result(result), .done(done), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // busy, stall, done packed as bits 2..0
  function automatic logic [31:0] flags();
    return {29'b0, busy, stall, done};
  endfunction

  function automatic logic [31:0] ref_result(input logic [3:0] ctrl, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    if (ctrl == CTRL_MUL) begin
      p = {32'b0, a} * {32'b0, b};
      return p[31:0];
    end
    if (b == 32'h0) return 32'hFFFF_FFFF;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
    sa = a;
    sb = b;
    return 32'(sa / sb);
  endfunction

  function automatic int ref_latency(input logic [3:0] ctrl, input logic [31:0] a,
                                     input logic [31:0] b);
    if (ctrl == CTRL_DIV && (b == 32'h0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  // Accept in the cycle after the next rising edge, then follow the operation to done.
  task automatic run_op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        input bit hold);
    int lat, exp_lat;
    bit seen;
    exp_q.push_back(ref_result(ctrl, a, b));
    exp_lat = ref_latency(ctrl, a, b);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b1; alu_ctrl = ctrl; op_a = a; op_b = b;
    @(negedge clk);
    check("accept_flags", flags(), 32'd2);
    check("result_held", result, last_res);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      lat++;
      @(negedge clk);
      if (done) seen = 1'b1;
      else check("run_flags", flags(), 32'd6);
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("done_flags", flags(), 32'd5);
    last_res = exp_q.pop_front();
    check("result", result, last_res);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("idle_after", flags(), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; alu_ctrl = 4'b0; op_a = '0; op_b = '0; flush = 1'b0;
    last_res = '0;
    #1;
    check("reset_flags", flags(), 32'd0);
    check("reset_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(CTRL_MUL, 32'd7, 32'hFFFF_FFFD, 1'b0);
    run_op(CTRL_DIV, 32'hFFFF_FFEC, 32'd3, 1'b0);
    run_op(CTRL_DIV, 32'd100, 32'd7, 1'b0);
    run_op(CTRL_DIV, 32'd1234, 32'd0, 1'b0);
    run_op(CTRL_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Non-M control code must be ignored entirely.
    @(posedge clk); #1;
    start = 1'b1; alu_ctrl = 4'b0010; op_a = 32'd5; op_b = 32'd6;
    @(negedge clk);
    check("other_ctrl_flags", flags(), 32'd0);
    check("other_ctrl_result", result, last_res);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("other_ctrl_after", flags(), 32'd0);

    // start held through DONE: one pulse only.
    run_op(CTRL_MUL, 32'd123, 32'd456, 1'b1);
    @(negedge clk);
    check("no_second_done", flags(), 32'd0);

    // Flush during MUL_RUN at cycle 10; DIV accepted in cycle 11.
    @(posedge clk); #1;
    start = 1'b1; alu_ctrl = CTRL_MUL; op_a = 32'd11; op_b = 32'd13;
    @(negedge clk);
    check("flush_accept", flags(), 32'd2);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (cyc == 10) flush = 1'b1;
      @(negedge clk);
      check("flush_run", flags(), 32'd6);
    end
    run_op(CTRL_DIV, 32'd9, 32'd2, 1'b0);

    // Asynchronous reset at cycle 5 of DIV_RUN.
    @(posedge clk); #1;
    start = 1'b1; alu_ctrl = CTRL_DIV; op_a = 32'd1000; op_b = 32'd3;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("pre_reset_run", flags(), 32'd6);
    end
    rst = 1'b1;
    #1;
    check("mid_reset_flags", flags(), 32'd0);
    check("mid_reset_result", result, 32'd0);
    last_res = '0;
    @(negedge clk);
    rst = 1'b0;
    run_op(CTRL_MUL, 32'd3, 32'd5, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [3:0]  c;
      logic [31:0] a, b;
      int kind;
      c = ($urandom_range(0, 1) == 0) ? CTRL_MUL : CTRL_DIV;
      a = $urandom;
      b = $urandom;
      kind = $urandom_range(0, 6);
      case (kind)
        0: begin c = CTRL_DIV; b = 32'h0; end
        1: begin c = CTRL_DIV; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
        3: b = $urandom_range(0, 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(c, a, b, bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
